// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts for START_PAT, deserialises DATA_W bits LSB-first and checks the stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to require an even-parity bit between payload and stop.
module serial_frame_rx #(
    parameter int                   START_LEN = 4,
    parameter logic [START_LEN-1:0] START_PAT = '0,
    parameter int                   DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    output logic [DATA_W-1:0] dOut,
    output logic              valid,
    output logic              busy,
    output logic              frameErr,
    output logic [7:0]        errCnt
);
    localparam int CW = $clog2(DATA_W + 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {HUNT, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {HUNT, DATA, STOP} state_t;
`endif
    state_t                 state_q, state_d;
    logic [START_LEN-1:0]   hunt_q, hunt_d, hunt_shift;
    logic [DATA_W-1:0]      data_q, data_d, dout_q, dout_d;
    logic [CW-1:0]          bit_q, bit_d;
    logic                   valid_q, valid_d, ferr_q, ferr_d;
    logic [7:0]             err_q, err_d;
    logic                   par_err;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            hunt_q    <= '1;
            data_q    <= '0;
            bit_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            err_q     <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hunt_q    <= hunt_d;
            data_q    <= data_d;
            bit_q     <= bit_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            err_q     <= err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end
    always_comb begin
        state_d    = state_q;
        hunt_d     = hunt_q;
        data_d     = data_q;
        bit_d      = bit_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        err_d      = err_q;
        hunt_shift = {hunt_q[START_LEN-2:0], sIn};
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        case (state_q)
            HUNT: begin
                // Refill with ones on a match so the next start must arrive in full.
                hunt_d = (hunt_shift == START_PAT) ? '1 : hunt_shift;
                if (hunt_shift == START_PAT) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < DATA_W; i++)
                    if (bit_q == CW'(i)) data_d[i] = sIn;
                bit_d = bit_q + 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                if (bit_q == CW'(DATA_W - 1)) state_d = PAR;
`else
                if (bit_q == CW'(DATA_W - 1)) state_d = STOP;
`endif
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PAR: begin
                par_err_d = sIn ^ (^data_q);
                state_d   = STOP;
            end
`endif
            STOP: begin
                dout_d  = (sIn && !par_err) ? data_q : dout_q;
                valid_d = sIn && !par_err;
                ferr_d  = !(sIn && !par_err);
                err_d   = (sIn && !par_err) ? err_q : err_q + 8'(err_q != 8'hFF);
                state_d = HUNT;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                par_err_d = 1'b0;
`endif
            end
            default: state_d = HUNT;
        endcase
    end
    assign dOut     = dout_q;
    assign valid    = valid_q;
    assign frameErr = ferr_q;
    assign errCnt   = err_q;
    assign busy     = (state_q != HUNT);
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: table-driven frames with a scoreboard queue checked whenever valid/frameErr fires.
module tb_serial_frame_rx;
    localparam int DW = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sIn = 1'b1;
    logic [DW-1:0] dOut;
    logic          valid, busy, frameErr;
    logic [7:0]    errCnt;
    int            checks = 0;
    int            errors = 0;
    int            run = 0;
    typedef struct {logic v; logic [7:0] d; logic [7:0] e;} exp_t;
    typedef struct {logic [7:0] d; logic stp; int gap; logic ev; logic [7:0] ed;} vec_t;
    exp_t          q[$];
    exp_t          mon_e;
    vec_t          vecs[8];
    logic [7:0]    exp_err = 8'd0;
    logic [7:0]    good;

    serial_frame_rx dut (
        .clk(clk), .rst(rst), .sIn(sIn), .dOut(dOut), .valid(valid),
        .busy(busy), .frameErr(frameErr), .errCnt(errCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) run = 0;
        else begin
            if (valid || frameErr) begin
                if (q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
                else begin
                    mon_e = q.pop_front();
                    check("valid", valid, mon_e.v);
                    check("frameErr", frameErr, !mon_e.v);
                    check("dOut", dOut, mon_e.d);
                    check("errCnt", errCnt, mon_e.e);
                end
            end
            if (busy) run++;
            else if (run != 0) begin
                check("busy_len", run, DW + 1 + PB);
                run = 0;
            end
        end
    end

    task automatic send_bit(input logic b);
        sIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stp, input logic pb,
                              input logic ev, input logic [7:0] ed);
        exp_t t;
        if (!ev) exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
        t.v = ev;
        t.d = ed;
        t.e = exp_err;
        q.push_back(t);
        repeat (4) send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (PB == 1) send_bit(pb);
        send_bit(stp);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 2, 1'b1, 8'hA5};
        vecs[1] = '{8'hA5, 1'b0, 2, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 2, 1'b1, 8'h3C};
        vecs[3] = '{8'h00, 1'b1, 4, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
        vecs[5] = '{8'h0F, 1'b0, 0, 1'b0, 8'hFF};
        vecs[6] = '{8'hF0, 1'b1, 3, 1'b1, 8'hF0};
        vecs[7] = '{8'h81, 1'b1, 2, 1'b1, 8'h81};

        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sIn = ~sIn;
            @(negedge clk);
            check("reset_outputs", {dOut, valid, busy, frameErr, errCnt}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sIn = 1'b1;
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_valid", valid, 1'b0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].d, vecs[i].stp, ^vecs[i].d, vecs[i].ev, vecs[i].ed);
            repeat (vecs[i].gap) send_bit(1'b1);
            if (vecs[i].gap != 0) begin
                check("frame_done", q.size(), 32'd0);
                check("idle_after_frame", busy, 1'b0);
            end
        end

        repeat (4) send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        sIn = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst_dout", dOut, 32'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_errcnt", errCnt, 32'd0);
        check("midrst_pulses", {valid, frameErr}, 32'd0);
        exp_err = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) send_bit(1'b1);
        check("midrst_no_output", q.size(), 32'd0);
        send_frame(8'h12, 1'b1, ^8'h12, 1'b1, 8'h12);
        repeat (2) send_bit(1'b1);
        check("after_rst_frame", q.size(), 32'd0);
        good = 8'h12;

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 8'h12);
        repeat (2) send_bit(1'b1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 8'h07);
        repeat (2) send_bit(1'b1);
        check("parity_frames", q.size(), 32'd0);
        good = 8'h07;
`endif

        for (int i = 0; i < 300; i++) send_frame(8'h55, 1'b0, ^8'h55, 1'b0, good);
        repeat (5) send_bit(1'b1);
        check("sat_errcnt", errCnt, 32'd255);
        check("sat_dout", dOut, good);
        check("sat_done", q.size(), 32'd0);
        repeat (5) send_bit(1'b1);
        check("sat_hold", errCnt, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
